// File: rtl/pifo_traffic_gen.sv
// rtl/pifo_traffic_gen.sv - multi-lane PIFO stimulus generator and min-first ordering checker
//
// Purpose:
//   Runs one push burst, one pop burst and a drain window on NPORT independent
//   lanes. Lane j always addresses tree j. Popped data is checked against the
//   set that lane pushed: exact sorted sequence for the deterministic modes,
//   and non-decreasing order plus XOR-sum/count match for the LFSR mode.
//
// Ports:
//   i_clk, i_rst     clock (rising edge), synchronous active-high reset
//   i_start          one-cycle pulse, starts a run when idle
//   i_mode           0 ascending, 1 descending, 2 LFSR, 3 interleaved ascending
//   i_burst_len      pushes per lane; 0 or above MAX_BURST means MAX_BURST
//   i_seed           LFSR seed for mode 2 (0 means 16'hACE1)
//   o_push           per-lane push strobe
//   o_push_data      lane j at [j*PTW +: PTW]
//   o_tree_id        lane j at [j*TIDW +: TIDW], constant j mod 2**TIDW
//   o_pop            per-lane pop strobe
//   i_pop_data       pop result, valid POP_LAT cycles after o_pop
//   o_busy           run in progress
//   o_done           one-cycle pulse in the last drain cycle
//   o_err            sticky mismatch flag, cleared when a run starts
//   o_err_lane       lowest mismatching lane of the first mismatch
//   o_pop_cnt        number of returned beats checked in this run
module pifo_traffic_gen #(
  parameter int NPORT     = 4,
  parameter int PTW       = 8,
  parameter int TIDW      = 2,
  parameter int MAX_BURST = 16,
  parameter int POP_LAT   = 1,
  parameter int DRAIN     = 8,
  localparam int BLW = $clog2(MAX_BURST + 1),
  localparam int LW  = (NPORT > 1) ? $clog2(NPORT) : 1
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic                  i_start,
  input  logic [1:0]            i_mode,
  input  logic [BLW-1:0]        i_burst_len,
  input  logic [15:0]           i_seed,
  output logic [NPORT-1:0]      o_push,
  output logic [NPORT*PTW-1:0]  o_push_data,
  output logic [NPORT*TIDW-1:0] o_tree_id,
  output logic [NPORT-1:0]      o_pop,
  input  logic [NPORT*PTW-1:0]  i_pop_data,
  output logic                  o_busy,
  output logic                  o_done,
  output logic                  o_err,
  output logic [LW-1:0]         o_err_lane,
  output logic [15:0]           o_pop_cnt
);

  // Phase counter must cover the longest phase: 2L (mode 3) or the drain window.
  localparam int KW = $clog2(2 * MAX_BURST + POP_LAT + DRAIN + 1);
  localparam logic [KW-1:0] DRAIN_LAST = KW'(POP_LAT + DRAIN - 1);
  // By drain cycle POP_LAT every returned beat has been folded into the
  // per-lane accumulators, so the mode-2 set comparison happens there
  // (needs DRAIN >= 1) and o_err is settled before o_done.
  localparam logic [KW-1:0] FINAL_AT   = KW'(POP_LAT);

  typedef enum logic [1:0] {
    S_IDLE,
    S_PUSH,
    S_POP,
    S_DRAIN
  } state_t;

  state_t          state, state_nxt;
  logic [KW-1:0]   k, k_nxt;

  logic [1:0]      mode;
  logic [BLW-1:0]  len;
  logic [15:0]     lfsr;
  logic [15:0]     lfsr_next;
  logic [15:0]     seed_in;
  logic [BLW-1:0]  len_in;
  logic [KW-1:0]   phase_len;
  logic            start_ok;

  logic [NPORT*PTW-1:0] push_vec;

  logic [NPORT-1:0] pop_dly [POP_LAT];
  logic [NPORT-1:0] ret;

  logic [PTW-1:0]  push_x   [NPORT];
  logic [BLW-1:0]  push_n   [NPORT];
  logic [PTW-1:0]  pop_x    [NPORT];
  logic [BLW-1:0]  pop_n    [NPORT];
  logic [PTW-1:0]  pop_last [NPORT];
  logic [PTW-1:0]  pop_val  [NPORT];
  logic [PTW-1:0]  exp_val  [NPORT];

  logic [NPORT-1:0] bad;
  logic [LW-1:0]    bad_lane;
  logic [15:0]      ret_cnt;
  logic             final_chk;

  // x^16 + x^14 + x^13 + x^11 + 1, Fibonacci form shifting right.
  assign lfsr_next = {lfsr[0] ^ lfsr[2] ^ lfsr[3] ^ lfsr[5], lfsr[15:1]};
  assign seed_in   = (i_seed == 16'd0) ? 16'hACE1 : i_seed;
  assign len_in    = (i_burst_len == '0 || i_burst_len > BLW'(MAX_BURST))
                     ? BLW'(MAX_BURST) : i_burst_len;
  // Interleaved mode spends two cycles per item so each lane still gets L.
  assign phase_len = (mode == 2'd3) ? KW'({len, 1'b0}) : KW'(len);
  assign start_ok  = i_start && (state == S_IDLE);
  assign ret       = pop_dly[POP_LAT-1];
  assign final_chk = (state == S_DRAIN) && (k == FINAL_AT);

  always_comb begin
    o_tree_id = '0;
    for (int j = 0; j < NPORT; j++) begin
      o_tree_id[j*TIDW +: TIDW] = TIDW'(j);
    end
  end

  // Push payload for the current cycle; all sums wrap at 2**PTW.
  always_comb begin
    push_vec = '0;
    for (int j = 0; j < NPORT; j++) begin
      case (mode)
        2'd0:    push_vec[j*PTW +: PTW] = PTW'(int'(k) + 1 + 16 * j);
        2'd1:    push_vec[j*PTW +: PTW] = PTW'(int'(len) - int'(k) + 16 * j);
        2'd2:    push_vec[j*PTW +: PTW] = lfsr[PTW-1:0] ^ PTW'(j);
        default: push_vec[j*PTW +: PTW] = PTW'(int'(k >> 1) + 1 + 16 * j);
      endcase
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state <= S_IDLE;
      k     <= '0;
    end else begin
      state <= state_nxt;
      k     <= k_nxt;
    end
  end

  always_comb begin
    state_nxt   = state;
    k_nxt       = k;
    o_push      = '0;
    o_push_data = '0;
    o_pop       = '0;
    o_done      = 1'b0;
    o_busy      = (state != S_IDLE);
    case (state)
      S_IDLE: begin
        if (i_start) begin
          state_nxt = S_PUSH;
          k_nxt     = '0;
        end
      end
      S_PUSH: begin
        o_push_data = push_vec;
        for (int j = 0; j < NPORT; j++) begin
          // Mode 3: lane j pushes when (k + j) is even.
          o_push[j] = (mode != 2'd3) || (k[0] == 1'(j % 2));
        end
        if (k == phase_len - KW'(1)) begin
          state_nxt = S_POP;
          k_nxt     = '0;
        end else begin
          k_nxt = k + KW'(1);
        end
      end
      S_POP: begin
        for (int j = 0; j < NPORT; j++) begin
          // Mode 3: opposite parity to the push phase.
          o_pop[j] = (mode != 2'd3) || (k[0] != 1'(j % 2));
        end
        if (k == phase_len - KW'(1)) begin
          state_nxt = S_DRAIN;
          k_nxt     = '0;
        end else begin
          k_nxt = k + KW'(1);
        end
      end
      S_DRAIN: begin
        if (k == DRAIN_LAST) begin
          o_done    = 1'b1;
          state_nxt = S_IDLE;
          k_nxt     = '0;
        end else begin
          k_nxt = k + KW'(1);
        end
      end
      default: begin
        state_nxt = S_IDLE;
        k_nxt     = '0;
      end
    endcase
  end

  // Checker: judge every returned beat and, in mode 2, the final set summary.
  always_comb begin
    bad      = '0;
    ret_cnt  = '0;
    bad_lane = '0;
    for (int j = 0; j < NPORT; j++) begin
      pop_val[j] = i_pop_data[j*PTW +: PTW];
      exp_val[j] = PTW'(int'(pop_n[j]) + 1 + 16 * j);
      if (ret[j]) begin
        ret_cnt = ret_cnt + 16'd1;
        if (mode == 2'd2) begin
          bad[j] = (pop_n[j] != '0) && (pop_val[j] < pop_last[j]);
        end else begin
          bad[j] = (pop_val[j] != exp_val[j]);
        end
      end
      if (final_chk && mode == 2'd2 &&
          (push_x[j] != pop_x[j] || push_n[j] != pop_n[j])) begin
        bad[j] = 1'b1;
      end
    end
    for (int j = NPORT - 1; j >= 0; j--) begin
      if (bad[j]) begin
        bad_lane = LW'(j);
      end
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      mode       <= 2'd0;
      len        <= '0;
      lfsr       <= 16'hACE1;
      o_err      <= 1'b0;
      o_err_lane <= '0;
      o_pop_cnt  <= '0;
      for (int s = 0; s < POP_LAT; s++) begin
        pop_dly[s] <= '0;
      end
      for (int j = 0; j < NPORT; j++) begin
        push_x[j]   <= '0;
        push_n[j]   <= '0;
        pop_x[j]    <= '0;
        pop_n[j]    <= '0;
        pop_last[j] <= '0;
      end
    end else begin
      pop_dly[0] <= o_pop;
      for (int s = 1; s < POP_LAT; s++) begin
        pop_dly[s] <= pop_dly[s-1];
      end
      if (start_ok) begin
        mode       <= i_mode;
        len        <= len_in;
        lfsr       <= seed_in;
        o_err      <= 1'b0;
        o_err_lane <= '0;
        o_pop_cnt  <= '0;
        for (int j = 0; j < NPORT; j++) begin
          push_x[j]   <= '0;
          push_n[j]   <= '0;
          pop_x[j]    <= '0;
          pop_n[j]    <= '0;
          pop_last[j] <= '0;
        end
      end else begin
        if (state == S_PUSH) begin
          lfsr <= lfsr_next;
        end
        for (int j = 0; j < NPORT; j++) begin
          if (o_push[j]) begin
            push_x[j] <= push_x[j] ^ o_push_data[j*PTW +: PTW];
            push_n[j] <= push_n[j] + BLW'(1);
          end
          if (ret[j]) begin
            pop_x[j]    <= pop_x[j] ^ pop_val[j];
            pop_n[j]    <= pop_n[j] + BLW'(1);
            pop_last[j] <= pop_val[j];
          end
        end
        o_pop_cnt <= o_pop_cnt + ret_cnt;
        if (|bad && !o_err) begin
          o_err      <= 1'b1;
          o_err_lane <= bad_lane;
        end
      end
    end
  end

endmodule

// File: tb/tb_pifo_traffic_gen.sv
// tb/tb_pifo_traffic_gen.sv - scoreboard bench for pifo_traffic_gen with a behavioural PIFO
module tb_pifo_traffic_gen;

  localparam int NPORT     = 4;
  localparam int PTW       = 8;
  localparam int TIDW      = 2;
  localparam int MAX_BURST = 16;
  localparam int POP_LAT   = 1;
  localparam int DRAIN     = 8;
  localparam int BLW       = $clog2(MAX_BURST + 1);

  logic                  clk = 1'b0;
  logic                  i_rst = 1'b1;
  logic                  i_start = 1'b0;
  logic [1:0]            i_mode = '0;
  logic [BLW-1:0]        i_burst_len = '0;
  logic [15:0]           i_seed = '0;
  logic [NPORT-1:0]      o_push;
  logic [NPORT*PTW-1:0]  o_push_data;
  logic [NPORT*TIDW-1:0] o_tree_id;
  logic [NPORT-1:0]      o_pop;
  logic [NPORT*PTW-1:0]  i_pop_data = '0;
  logic                  o_busy;
  logic                  o_done;
  logic                  o_err;
  logic [1:0]            o_err_lane;
  logic [15:0]           o_pop_cnt;

  pifo_traffic_gen #(
    .NPORT(NPORT), .PTW(PTW), .TIDW(TIDW),
    .MAX_BURST(MAX_BURST), .POP_LAT(POP_LAT), .DRAIN(DRAIN)
  ) dut (
    .i_clk(clk), .i_rst(i_rst), .i_start(i_start), .i_mode(i_mode),
    .i_burst_len(i_burst_len), .i_seed(i_seed),
    .o_push(o_push), .o_push_data(o_push_data), .o_tree_id(o_tree_id),
    .o_pop(o_pop), .i_pop_data(i_pop_data),
    .o_busy(o_busy), .o_done(o_done), .o_err(o_err),
    .o_err_lane(o_err_lane), .o_pop_cnt(o_pop_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [PTW-1:0] val;
    int             rel;
  } push_t;

  typedef struct {
    logic        err;
    logic [1:0]  lane;
    logic [15:0] cnt;
    int          lat;
  } res_t;

  int n_vec = 0;
  int n_bad = 0;
  int cyc = 0;
  int start_cyc = 0;
  int done_cnt = 0;

  push_t exp_push [NPORT][$];
  res_t  exp_res [$];
  logic [PTW-1:0] pifo_q [NPORT][$];
  int    pop_idx [NPORT];
  logic [NPORT*PTW-1:0] pend = '0;
  bit    corrupt = 1'b0;

  push_t          e_push;
  res_t           e_res;
  int             mi;
  logic [PTW-1:0] pv;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  // Behavioural PIFO: pop data appears one cycle after the pop strobe.
  always begin
    @(posedge clk);
    #1;
    i_pop_data = pend;
  end

  // Monitor: scoreboard pushes, serve pops from the PIFO model, score runs.
  always @(negedge clk) begin
    if (i_rst) begin
      for (int j = 0; j < NPORT; j++) begin
        pifo_q[j].delete();
        pop_idx[j] = 0;
      end
      pend = '0;
    end else begin
      if (i_start && !o_busy) begin
        start_cyc = cyc + 1;
        for (int j = 0; j < NPORT; j++) pop_idx[j] = 0;
      end
      for (int j = 0; j < NPORT; j++) begin
        if (o_push[j]) begin
          if (exp_push[j].size() == 0) begin
            check("push_unexpected", 32'(j), 32'hFFFF_FFFF);
          end else begin
            e_push = exp_push[j].pop_front();
            check("push_data", 32'(o_push_data[j*PTW +: PTW]), 32'(e_push.val));
            check("push_time", 32'(cyc - start_cyc), 32'(e_push.rel));
          end
          pifo_q[j].push_back(o_push_data[j*PTW +: PTW]);
        end
        if (o_pop[j]) begin
          pv = '0;
          if (pifo_q[j].size() > 0) begin
            mi = 0;
            for (int q = 1; q < pifo_q[j].size(); q++) begin
              if (pifo_q[j][q] < pifo_q[j][mi]) mi = q;
            end
            pv = pifo_q[j][mi];
            pifo_q[j].delete(mi);
          end
          if (corrupt && j == 2 && pop_idx[j] == 1) pv = 8'hFF;
          pop_idx[j]++;
          pend[j*PTW +: PTW] = pv;
        end
      end
      if (o_done) begin
        done_cnt++;
        if (exp_res.size() == 0) begin
          check("done_unexpected", 32'(o_done), 32'd0);
        end else begin
          e_res = exp_res.pop_front();
          check("run_err", 32'(o_err), 32'(e_res.err));
          check("run_err_lane", 32'(o_err_lane), 32'(e_res.lane));
          check("run_pop_cnt", 32'(o_pop_cnt), 32'(e_res.cnt));
          check("run_latency", 32'(cyc - start_cyc + 1), 32'(e_res.lat));
        end
      end
    end
  end

  task automatic expect_pushes(input int mode, input int blen, input logic [15:0] seed, output int len);
    logic [15:0] s;
    push_t p;
    len = (blen == 0 || blen > MAX_BURST) ? MAX_BURST : blen;
    s = (seed == 16'd0) ? 16'hACE1 : seed;
    if (mode == 3) begin
      for (int k = 0; k < 2 * len; k++)
        for (int j = 0; j < NPORT; j++)
          if (((k + j) % 2) == 0) begin
            p.val = PTW'(k / 2 + 1 + 16 * j);
            p.rel = k;
            exp_push[j].push_back(p);
          end
    end else begin
      for (int k = 0; k < len; k++) begin
        for (int j = 0; j < NPORT; j++) begin
          case (mode)
            0:       p.val = PTW'(k + 1 + 16 * j);
            1:       p.val = PTW'(len - k + 16 * j);
            default: p.val = s[PTW-1:0] ^ PTW'(j);
          endcase
          p.rel = k;
          exp_push[j].push_back(p);
        end
        s = {s[0] ^ s[2] ^ s[3] ^ s[5], s[15:1]};
      end
    end
  endtask

  task automatic pulse_start(input int mode, input int blen, input logic [15:0] seed);
    @(posedge clk);
    #1;
    i_mode      = 2'(mode);
    i_burst_len = BLW'(blen);
    i_seed      = seed;
    i_start     = 1'b1;
    @(posedge clk);
    #1;
    i_start = 1'b0;
    check("start_busy", 32'(o_busy), 32'd1);
    check("start_err_clr", 32'(o_err), 32'd0);
    check("start_cnt_clr", 32'(o_pop_cnt), 32'd0);
  endtask

  task automatic run(input int mode, input int blen, input logic [15:0] seed,
                     input logic err, input logic [1:0] lane);
    int len;
    int plen;
    int d0;
    int t;
    res_t r;
    expect_pushes(mode, blen, seed, len);
    plen  = (mode == 3) ? 2 * len : len;
    r.err = err;
    r.lane = lane;
    r.cnt = 16'(NPORT * len);
    r.lat = 2 * plen + POP_LAT + DRAIN;
    exp_res.push_back(r);
    d0 = done_cnt;
    pulse_start(mode, blen, seed);
    t = 0;
    while (done_cnt == d0 && t < 400) begin
      @(posedge clk);
      t++;
    end
    if (done_cnt == d0) check("done_timeout", 32'(t), 32'd0);
    #1;
    check("idle_after_done", 32'(o_busy), 32'd0);
    for (int j = 0; j < NPORT; j++) begin
      check("push_missing", 32'(exp_push[j].size()), 32'd0);
      exp_push[j].delete();
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int len;
    int d0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_push", 32'(o_push), 32'd0);
    check("rst_pop", 32'(o_pop), 32'd0);
    check("rst_busy", 32'(o_busy), 32'd0);
    check("rst_done", 32'(o_done), 32'd0);
    check("rst_err", 32'(o_err), 32'd0);
    check("rst_err_lane", 32'(o_err_lane), 32'd0);
    check("rst_pop_cnt", 32'(o_pop_cnt), 32'd0);
    check("rst_tree_id", 32'(o_tree_id), 32'hE4);
    i_rst = 1'b0;

    run(0, 4, 16'h0000, 1'b0, 2'd0);           // ascending
    run(1, 4, 16'h0000, 1'b0, 2'd0);           // descending
    run(2, 8, 16'h0000, 1'b0, 2'd0);           // LFSR, seed 0 -> ACE1
    corrupt = 1'b1;
    run(0, 4, 16'h0000, 1'b1, 2'd2);           // lane 2, 2nd pop forced to FF
    corrupt = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    check("err_sticky", 32'(o_err), 32'd1);
    check("err_lane_sticky", 32'(o_err_lane), 32'd2);
    run(0, 0, 16'h0000, 1'b0, 2'd0);           // length 0 -> MAX_BURST
    run(1, 20, 16'h0000, 1'b0, 2'd0);          // length > MAX_BURST clamps
    run(3, 4, 16'h0000, 1'b0, 2'd0);           // interleaved
    run(2, 5, 16'h1234, 1'b0, 2'd0);           // LFSR, explicit seed

    // Reset during the pop phase aborts with no o_done.
    expect_pushes(0, 4, 16'h0000, len);
    d0 = done_cnt;
    pulse_start(0, 4, 16'h0000);
    repeat (5) @(posedge clk);
    #1;
    check("abort_in_pop", 32'(o_pop), 32'hF);
    i_rst = 1'b1;
    @(posedge clk);
    #1;
    check("abort_push", 32'(o_push), 32'd0);
    check("abort_pop", 32'(o_pop), 32'd0);
    check("abort_busy", 32'(o_busy), 32'd0);
    check("abort_pop_cnt", 32'(o_pop_cnt), 32'd0);
    @(posedge clk);
    #1;
    i_rst = 1'b0;
    for (int j = 0; j < NPORT; j++) exp_push[j].delete();
    repeat (30) @(posedge clk);
    #1;
    check("abort_no_done", 32'(done_cnt), 32'(d0));
    run(1, 3, 16'h0000, 1'b0, 2'd0);

    repeat (3) @(posedge clk);
    #1;
    check("results_left", 32'(exp_res.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
